// File: rtl/line_ram_writer.sv
// rtl/line_ram_writer.sv - double-buffered 160-cell line RAM fed by DMA pixel strobes
module line_ram_writer #(
    parameter int LINE_W = 160,
    parameter int IDX_W  = 5
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic [7:0]       DataB,
    input  logic             palette_w,
    input  logic             wm_w,
    input  logic             input_w,
    input  logic             pixels_w,
    input  logic             kangaroo,
    input  logic             line_swap,
    input  logic [7:0]       rd_addr,
    output logic [IDX_W-1:0] rd_index,
    output logic             wr_sel
);

    localparam logic [8:0] LINE_LIM = 9'(LINE_W);

    logic [IDX_W-1:0] bank [2][LINE_W];
    logic [2:0]       pal;
    logic             wm;
    logic [7:0]       hpos;

    logic [7:0]       px_addr [4];
    logic [IDX_W-1:0] px_val  [4];
    logic [1:0]       px_c    [4];
    logic [3:0]       px_en;

    // Up to four pixel writes per byte; 160B uses only the first two lanes.
    always_comb begin
        px_en = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            px_addr[k] = hpos + 8'(k);
            px_c[k]    = DataB[7-2*k -: 2];
            px_val[k]  = '0;
            if (wm) begin
                if (k < 2) begin
                    px_val[k] = IDX_W'({pal[2], DataB[3-2*k -: 2], px_c[k]});
                end
            end else begin
                px_val[k] = IDX_W'({pal, px_c[k]});
            end
            px_en[k] = pixels_w && !line_swap
                       && (!wm || (k < 2))
                       && ({1'b0, px_addr[k]} < LINE_LIM)
                       && (kangaroo || (px_c[k] != 2'b00));
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < LINE_W; i++) begin
                    bank[b][i] <= '0;
                end
            end
            rd_index <= '0;
            wr_sel   <= 1'b0;
            pal      <= 3'b000;
            wm       <= 1'b0;
            hpos     <= 8'd0;
        end else begin
            if (palette_w) begin
                pal <= DataB[7:5];
            end
            if (wm_w) begin
                wm <= DataB[7];
            end
            if (pixels_w && !line_swap) begin
                hpos <= hpos + (wm ? 8'd2 : 8'd4);
            end else if (input_w) begin
                hpos <= DataB;
            end

            if ({1'b0, rd_addr} < LINE_LIM) begin
                rd_index <= bank[~wr_sel][rd_addr];
            end else begin
                rd_index <= '0;
            end

            // The bank leaving scan-out becomes the new, empty write bank.
            if (line_swap) begin
                wr_sel <= ~wr_sel;
                for (int i = 0; i < LINE_W; i++) begin
                    bank[~wr_sel][i] <= '0;
                end
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (px_en[k]) begin
                        bank[wr_sel][px_addr[k]] <= px_val[k];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_line_ram_writer.sv
// tb/tb_line_ram_writer.sv - scoreboard bench for line_ram_writer with a behavioural line model
module tb_line_ram_writer;

    logic       sysclk = 1'b0;
    logic       reset;
    logic [7:0] DataB;
    logic       palette_w, wm_w, input_w, pixels_w, kangaroo, line_swap;
    logic [7:0] rd_addr;
    logic [4:0] rd_index;
    logic       wr_sel;

    always #5 sysclk = ~sysclk;

    line_ram_writer dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .DataB     (DataB),
        .palette_w (palette_w),
        .wm_w      (wm_w),
        .input_w   (input_w),
        .pixels_w  (pixels_w),
        .kangaroo  (kangaroo),
        .line_swap (line_swap),
        .rd_addr   (rd_addr),
        .rd_index  (rd_index),
        .wr_sel    (wr_sel)
    );

    typedef struct {
        logic [4:0] idx;
        logic       sel;
        int         tag;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic chk_req  = 1'b0;
    logic chk_seen = 1'b0;

    // Reference state: two lines of colour indices plus the DMA registers.
    logic [4:0] m_bank [2][160];
    logic       m_sel;
    logic [2:0] m_pal;
    logic       m_wm;
    logic [7:0] m_hpos;

    task automatic cyc(input logic rs, input logic [7:0] d, input logic pw, input logic ww,
                       input logic iw, input logic xw, input logic kg, input logic sw,
                       input logic [7:0] ra, input int exp_idx, input int tag);
        exp_t       e;
        logic [2:0] np;
        logic       nw;
        logic [7:0] nh;
        logic [1:0] c;
        logic [4:0] v;
        int         n;
        int         a;
        reset = rs; DataB = d; palette_w = pw; wm_w = ww; input_w = iw;
        pixels_w = xw; kangaroo = kg; line_swap = sw; rd_addr = ra;

        if (rs || ra >= 8'd160) e.idx = 5'd0;
        else                    e.idx = m_bank[!m_sel][ra];
        if (exp_idx >= 0) e.idx = 5'(exp_idx);

        if (rs) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < 160; i++) m_bank[b][i] = 5'd0;
            m_sel = 1'b0; m_pal = 3'd0; m_wm = 1'b0; m_hpos = 8'd0;
        end else begin
            np = m_pal; nw = m_wm; nh = m_hpos;
            if (pw) np = d[7:5];
            if (ww) nw = d[7];
            if (iw) nh = d;
            if (sw) begin
                m_sel = !m_sel;
                for (int i = 0; i < 160; i++) m_bank[m_sel][i] = 5'd0;
            end else if (xw) begin
                n = m_wm ? 2 : 4;
                for (int k = 0; k < n; k++) begin
                    c = d[7-2*k -: 2];
                    v = m_wm ? {m_pal[2], d[3-2*k -: 2], c} : {m_pal, c};
                    a = (int'(m_hpos) + k) % 256;
                    if (a < 160 && (kg || c != 2'd0)) m_bank[m_sel][a] = v;
                end
                nh = 8'((int'(m_hpos) + n) % 256);
            end
            m_pal = np; m_wm = nw; m_hpos = nh;
        end

        e.sel = m_sel;
        e.tag = tag;
        sb.push_back(e);
        chk_req = 1'b1;
        @(posedge sysclk);
        #1;
    endtask

    task automatic wpal(input logic [7:0] d);            cyc(0, d, 1, 0, 0, 0, 0, 0, 8'd0, -1, 0); endtask
    task automatic wwm(input logic [7:0] d);             cyc(0, d, 0, 1, 0, 0, 0, 0, 8'd0, -1, 0); endtask
    task automatic wpos(input logic [7:0] d);            cyc(0, d, 0, 0, 1, 0, 0, 0, 8'd0, -1, 0); endtask
    task automatic wpix(input logic [7:0] d, input logic kg); cyc(0, d, 0, 0, 0, 1, kg, 0, 8'd0, -1, 0); endtask
    task automatic swp();                                cyc(0, 8'd0, 0, 0, 0, 0, 0, 1, 8'd0, -1, 0); endtask
    task automatic rst();                                cyc(1, 8'd0, 0, 0, 0, 0, 0, 0, 8'd0, -1, 0); endtask
    task automatic rd(input logic [7:0] ra, input int exp_idx, input int tag);
        cyc(0, 8'd0, 0, 0, 0, 0, 0, 0, ra, exp_idx, tag);
    endtask

    always @(posedge sysclk) chk_seen <= chk_req;

    always @(negedge sysclk) begin
        exp_t e;
        if (chk_seen) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_underflow: output with no expected entry");
            end else begin
                e = sb.pop_front();
                if (rd_index !== e.idx) begin
                    bad++;
                    $display("FAIL rd_index tag=%0d: got %h expected %h", e.tag, rd_index, e.idx);
                end
                total++;
                if (wr_sel !== e.sel) begin
                    bad++;
                    $display("FAIL wr_sel tag=%0d: got %b expected %b", e.tag, wr_sel, e.sel);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic [7:0] ra;
        int         r;
        rst();
        for (int i = 0; i < 8; i++) rd(8'(i * 37), 0, 0);

        // 1: 160A with transparent colour 0
        wpal(8'hA0); wwm(8'h00); wpos(8'd10); wpix(8'hE4, 0); swp();
        rd(8'd10, 5'h17, 1); rd(8'd11, 5'h16, 1); rd(8'd12, 5'h15, 1); rd(8'd13, 5'h00, 1);

        // 2: 160B
        wpal(8'h80); wwm(8'h80); wpos(8'd20); wpix(8'hB6, 0); swp();
        rd(8'd20, 5'h16, 2); rd(8'd21, 5'h1B, 2); rd(8'd22, 5'h00, 2);

        // 3: kangaroo opaque vs transparent colour 0
        wwm(8'h00); wpal(8'hE0); wpos(8'd30); wpix(8'hFF, 0);
        wpal(8'h40); wpos(8'd30); wpix(8'h00, 1); swp();
        rd(8'd30, 5'h08, 3); rd(8'd31, 5'h08, 3); rd(8'd32, 5'h08, 3); rd(8'd33, 5'h08, 3);
        wpal(8'hE0); wpos(8'd30); wpix(8'hFF, 0);
        wpal(8'h40); wpos(8'd30); wpix(8'h00, 0); swp();
        rd(8'd30, 5'h1F, 3); rd(8'd33, 5'h1F, 3);

        // 4: right-edge clipping and hpos wrap
        wpal(8'hE0); wpos(8'd158); wpix(8'hFF, 0); wpos(8'd254); wpix(8'hFF, 0); swp();
        rd(8'd157, 5'h00, 4); rd(8'd158, 5'h1F, 4); rd(8'd159, 5'h1F, 4);
        rd(8'd0, 5'h1F, 4); rd(8'd1, 5'h1F, 4); rd(8'd2, 5'h00, 4); rd(8'd200, 5'h00, 4);

        // 5: back-to-back bytes, then a byte coincident with line_swap
        wpos(8'd0); wpix(8'hFF, 0); wpix(8'hFF, 0); wpix(8'hFF, 0); wpix(8'hFF, 0); swp();
        rd(8'd0, 5'h1F, 5); rd(8'd11, 5'h1F, 5); rd(8'd15, 5'h1F, 5); rd(8'd16, 5'h00, 5);
        cyc(0, 8'hFF, 0, 0, 0, 1, 1, 1, 8'd0, -1, 5);
        wpix(8'hFF, 0); swp();
        rd(8'd0, 5'h00, 5); rd(8'd16, 5'h1F, 5); rd(8'd19, 5'h1F, 5); rd(8'd20, 5'h00, 5);

        // 6: reset mid-line
        wpal(8'hE0); wpos(8'd40); wpix(8'hFF, 0); swp(); wpos(8'd50); wpix(8'hFF, 0); rst();
        rd(8'd40, 5'h00, 6); rd(8'd50, 5'h00, 6); swp(); rd(8'd50, 5'h00, 6);
        rst();

        for (int it = 0; it < 4000; it++) begin
            r  = $urandom_range(0, 19);
            d  = 8'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 159));
            case (r)
                0, 1:   cyc(0, d, 1, 0, 0, 0, 0, 0, ra, -1, 100);
                2:      cyc(0, d, 0, 1, 0, 0, 0, 0, ra, -1, 100);
                3, 4:   cyc(0, ($urandom_range(0, 1) == 1) ? 8'($urandom_range(150, 255)) : d,
                            0, 0, 1, 0, 0, 0, ra, -1, 100);
                5, 6, 7, 8, 9, 10, 11, 12, 13:
                        cyc(0, d, 0, 0, 0, 1, 1'($urandom), 0, ra, -1, 100);
                14:     cyc(0, d, 1'($urandom), 0, 0, 1'($urandom), 1'($urandom), 1, ra, -1, 100);
                15:     if ($urandom_range(0, 7) == 0) cyc(1, d, 0, 0, 0, 0, 0, 0, ra, -1, 100);
                        else cyc(0, d, 0, 0, 0, 0, 0, 0, ra, -1, 100);
                default: cyc(0, d, 0, 0, 0, 0, 0, 0, ra, -1, 100);
            endcase
        end

        chk_req = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
